bus_master_if: RTL and testbench
================================

// Module: bus_master_if
// PURPOSE
//  Bus initiator for the SoC peripheral bus; counterpart of the slave ports
//  (cs_/as_/rw/addr/rd_data/rdy_) on timer, uart, gpio.
//  Takes one CPU load/store, arbitrates for the bus, issues a single as_ strobe.
//  Waits for the slave's rdy_ pulse and returns read data.
//  Stalls the CPU while a transfer is open; watchdog aborts hung transfers.
// PARAMETERS
//  ADDR_W   30   word address width driven on bus_addr
//  DATA_W   32   data width
//  TIMEOUT  255  cycles waited for rdy_ after as_; 0 disables watchdog
// PORTS
//  clk          in   1       single clock, all state on posedge
//  rst          in   1       asynchronous, active-low reset
//  req          in   1       CPU access request, held until busy==0
//  rw           in   1       `READ / `WRITE (stddef.vh)
//  addr         in   ADDR_W  CPU word address
//  wr_data      in   DATA_W  store data
//  rd_data      out  DATA_W  load result, registered
//  busy         out  1       stall to CPU
//  err          out  1       one-cycle pulse: transfer aborted by watchdog
//  bus_req_     out  1       arbiter request, active-low
//  bus_grnt_    in   1       arbiter grant, active-low
//  bus_as_      out  1       address strobe, active-low
//  bus_rw       out  1       bus direction
//  bus_addr     out  ADDR_W  bus address
//  bus_wr_data  out  DATA_W  bus write data
//  bus_rd_data  in   DATA_W  OR-combined slave read data (idle slaves drive 0)
//  bus_rdy_     in   1       slave ready, active-low, one-cycle pulse
// BEHAVIOUR
//  Reset (async, immediate):
//   state=IDLE, rd_data=0, err=0, bus_req_=1, bus_as_=1, bus_rw=`READ,
//   bus_addr=0, bus_wr_data=0, watchdog=0; applies mid-transfer too.
//  FSM IDLE->REQ->ACCESS->DONE->IDLE:
//   IDLE: on req=1, latch rw/addr/wr_data into regs -> REQ.
//   REQ: bus_req_=0; when bus_grnt_==0 at clock edge -> ACCESS.
//   ACCESS: bus_req_=0; bus_as_=0 in first ACCESS cycle only (one strobe per transfer).
//    bus_rw/addr/wr_data are driven from the latched regs for all of ACCESS.
//    bus_rdy_==0 at an edge -> DONE, and on reads rd_data<=bus_rd_data.
//    Otherwise watchdog++; when watchdog==TIMEOUT-1 and rdy_ still high
//    -> DONE with err=1; on reads rd_data<=0.
//   DONE: bus_req_=1, err pulse visible this cycle only -> IDLE unconditionally.
//  busy = req && state!=DONE (combinational); busy=0 in DONE releases the CPU.
//  Bus outputs are 0 (and as_=1) outside ACCESS, as required by the OR-bus.
//  Writes leave rd_data unchanged; rd_data holds until the next read completes.
//  Latency (grant ready, 1-cycle slave): req@c0, REQ@c1, as_@c2, rdy_@c3,
//   DONE/busy=0@c4; busy high c0..c3; next req is accepted from IDLE @c5.
//  Watchdog clears on entry to ACCESS; TIMEOUT=0: no abort, waits forever.
//  Edge cases:
//   - rdy_ and timeout on the same edge: rdy_ wins, err=0.
//   - rdy_ outside ACCESS: ignored.
//   - grant withdrawn during ACCESS: ignored (arbiter must hold the grant).
//   - req dropped mid-transfer: transfer completes, result is discarded.
//  Width rules:
//   - watchdog is $clog2(TIMEOUT+1) bits and saturates; never wraps.
//   - addr/data pass through unmodified.
// STRUCTURE
//  Shared header bus.vh: `BUS_STATE_IDLE/REQ/ACCESS/DONE (2-bit encoding),
//   `BUS_ADDR_W, `BUS_DATA_W.
//  stddef.vh provides `ENABLE_/`DISABLE_/`READ/`WRITE/`RST_EDGE/`RST_ENABLE.
//  One sub-module, bus_watchdog (clear, enable, TIMEOUT param -> expire),
//   reusable by other masters.
//  FSM, latches and output muxing are in this module.
// TESTING
//  1 Read timer: addr=1, grant tied 0, 1-cycle slave returns 32'h0000_00FF
//    -> as_ low exactly 1 cycle @c2, rd_data=32'hFF, busy high c0..c3.
//  2 Write 32'h1234_5678 to addr 2 -> bus_rw=`WRITE and data stable through rdy_;
//    rd_data unchanged; as_ low exactly once.
//  3 Grant delayed 5 cycles -> bus_as_ stays 1 and bus_addr stays 0 until grant;
//    as_ on the cycle after the grant edge.
//  4 TIMEOUT=4, slave never ready, read -> err pulse 1 cycle, rd_data=0,
//    busy low in that DONE cycle; second TIMEOUT=4 case: rdy_ on the 4th wait
//    cycle -> err=0, data taken.
//  5 Assert rst (0) while in ACCESS -> same cycle bus_as_=1, bus_req_=1,
//    rd_data=0; after release, a new req completes normally.
//  6 Back-to-back: req held across 3 reads with slave data 1,2,3 ->
//    3 strobes, rd_data=1,2,3 in successive DONE cycles, no lost or duplicate as_.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// Shared types and constants for the peripheral-bus initiator and its helpers.
// Bus control strobes are active-low; READ/WRITE is the bus direction encoding.
package bus_master_if_pkg;

  localparam int BUS_ADDR_W = 30;
  localparam int BUS_DATA_W = 32;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'h0,
    ST_REQ    = 2'h1,
    ST_ACCESS = 2'h2,
    ST_DONE   = 2'h3
  } bus_state_e;

  // Counter width able to hold 0..timeout; a disabled watchdog still needs one bit.
  function automatic int wdog_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating cycle counter that flags the last permitted wait cycle of a transfer.
// TIMEOUT=0 disables expiry entirely.
module bus_watchdog
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = wdog_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = (TIMEOUT > 0) && enable && (cnt == CNT_LAST);

endmodule

// File: rtl/bus_master_if.sv
// Single-transfer bus initiator: arbitrates, issues one address strobe, waits for
// the slave's ready pulse (or the watchdog) and returns load data to the CPU.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_IDLE   | waiting for a CPU request; request fields latched on accept
//  ST_REQ    | bus_req_ asserted, waiting for bus_grnt_
//  ST_ACCESS | bus driven; as_ in first cycle only; waiting for rdy_/timeout
//  ST_DONE   | one-cycle completion: CPU released, err pulse, bus released
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bus_state_e        state;
  logic              rw_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic wdog_clear;
  logic wdog_en;
  logic wdog_expire;

  assign wdog_clear = (state == ST_REQ) && (bus_grnt_ == ENABLE_);
  assign wdog_en    = (state == ST_ACCESS);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wdog_clear),
    .enable (wdog_en),
    .expire (wdog_expire)
  );

  assign busy = req && (state != ST_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rw_r        <= READ;
      addr_r      <= '0;
      wr_data_r   <= '0;
      rd_data     <= '0;
      err         <= 1'b0;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            rw_r      <= rw;
            addr_r    <= addr;
            wr_data_r <= wr_data;
            bus_req_  <= ENABLE_;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_grnt_ == ENABLE_) begin
            bus_as_     <= ENABLE_;
            bus_rw      <= rw_r;
            bus_addr    <= addr_r;
            bus_wr_data <= wr_data_r;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus_as_ <= DISABLE_;
          // Ready has priority over a watchdog expiry on the same edge.
          if ((bus_rdy_ == ENABLE_) || wdog_expire) begin
            if (rw_r == READ) begin
              rd_data <= (bus_rdy_ == ENABLE_) ? bus_rd_data : '0;
            end
            err         <= (bus_rdy_ != ENABLE_);
            bus_req_    <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if with a behavioural latency-programmable slave.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          err;
  logic          bus_req_;
  logic          bus_grnt_;
  logic          bus_as_;
  logic          bus_rw;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_rdy_;

  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy), .err(err), .bus_req_(bus_req_),
    .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic e; logic [DW-1:0] d; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] slave_q[$];
  logic [DW-1:0] exp_rd;

  int slave_lat = 1;   // rdy_ this many cycles after the as_ cycle; 0 = never
  bit stray = 1'b0;    // one rdy_ pulse with junk data, outside any access
  int cd = 0;

  int            as_cnt = 0;
  logic          as_rw, rdy_rw;
  logic [AW-1:0] as_addr, rdy_addr;
  logic [DW-1:0] as_wd, rdy_wd;

  int cyc;
  bit ok;

  // Slave: drives the bus inputs on the falling edge, one-cycle rdy_ pulses.
  initial begin
    bus_rdy_ = 1'b1;
    bus_rd_data = '0;
    forever begin
      @(negedge clk);
      bus_rdy_ = 1'b1;
      bus_rd_data = '0;
      if (stray) begin
        bus_rdy_ = 1'b0;
        bus_rd_data = 32'hDEAD_BEEF;
        stray = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus_rdy_ = 1'b0;
          if (bus_rw == READ && slave_q.size() > 0) bus_rd_data = slave_q.pop_front();
        end
      end
      if (bus_as_ === 1'b0 && slave_lat > 0) cd = slave_lat;
    end
  end

  // Bus monitor: records strobes and the bus fields seen during as_ and rdy_.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus_as_ === 1'b0) begin
        as_cnt++;
        as_rw = bus_rw; as_addr = bus_addr; as_wd = bus_wr_data;
      end
      if (bus_rdy_ === 1'b0) begin
        rdy_rw = bus_rw; rdy_addr = bus_addr; rdy_wd = bus_wr_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, failures=%0d", failures);
    $fatal(1, "bench stopped");
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_done(input int max_cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      step();
      if (busy === 1'b0) begin
        cyc = i;
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; rw = READ; addr = '0; wr_data = '0; bus_grnt_ = 1'b0;
    exp_rd = '0;
    step(); step();
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1) begin failures++; $display("FAIL reset_strobes: req_=%b as_=%b want 1 1", bus_req_, bus_as_); end
    checks++; if (bus_rw !== READ || bus_addr !== '0 || bus_wr_data !== '0) begin failures++; $display("FAIL reset_bus: rw=%b addr=%h wd=%h want %b 0 0", bus_rw, bus_addr, bus_wr_data, READ); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_read_timer();
    exp_t e;
    int n0;
    slave_lat = 1;
    slave_q.push_back(32'h0000_00FF);
    sb.push_back('{e: 1'b0, d: 32'h0000_00FF});
    exp_rd = 32'h0000_00FF;
    n0 = as_cnt;
    step();
    req = 1'b1; rw = READ; addr = 30'd1; wr_data = '0;
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_c0: got %b want 1", busy); end
    step();
    checks++; if (busy !== 1'b1 || bus_req_ !== 1'b0 || bus_as_ !== 1'b1) begin failures++; $display("FAIL rd_c1: busy=%b req_=%b as_=%b want 1 0 1", busy, bus_req_, bus_as_); end
    step();
    checks++; if (busy !== 1'b1 || bus_as_ !== 1'b0 || bus_addr !== 30'd1 || bus_rw !== READ) begin failures++; $display("FAIL rd_c2: busy=%b as_=%b addr=%h rw=%b want 1 0 1 %b", busy, bus_as_, bus_addr, bus_rw, READ); end
    step();
    checks++; if (busy !== 1'b1 || bus_as_ !== 1'b1) begin failures++; $display("FAIL rd_c3: busy=%b as_=%b want 1 1", busy, bus_as_); end
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd_c4_busy: got %b want 0", busy); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL rd_data: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    checks++; if (as_cnt - n0 != 1) begin failures++; $display("FAIL rd_strobes: got %0d want 1", as_cnt - n0); end
    req = 1'b0;
    step();
  endtask

  task automatic test_write();
    exp_t e;
    int n0;
    slave_lat = 1;
    sb.push_back('{e: 1'b0, d: exp_rd});
    n0 = as_cnt;
    step();
    req = 1'b1; rw = WRITE; addr = 30'd2; wr_data = 32'h1234_5678;
    wait_done(20);
    checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL wr_latency: done=%b cycles=%0d want 1 4", ok, cyc); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL wr_rd_data_kept: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    checks++; if (as_rw !== WRITE || as_addr !== 30'd2 || as_wd !== 32'h1234_5678) begin failures++; $display("FAIL wr_at_as: rw=%b addr=%h wd=%h want %b 2 12345678", as_rw, as_addr, as_wd, WRITE); end
    checks++; if (rdy_rw !== WRITE || rdy_addr !== 30'd2 || rdy_wd !== 32'h1234_5678) begin failures++; $display("FAIL wr_at_rdy: rw=%b addr=%h wd=%h want %b 2 12345678", rdy_rw, rdy_addr, rdy_wd, WRITE); end
    checks++; if (as_cnt - n0 != 1) begin failures++; $display("FAIL wr_strobes: got %0d want 1", as_cnt - n0); end
    req = 1'b0;
    step();
    checks++; if (bus_wr_data !== '0 || bus_rw !== READ || bus_addr !== '0) begin failures++; $display("FAIL wr_bus_released: wd=%h rw=%b addr=%h want 0 %b 0", bus_wr_data, bus_rw, bus_addr, READ); end
  endtask

  task automatic test_grant_delay();
    exp_t e;
    slave_lat = 1;
    bus_grnt_ = 1'b1;
    slave_q.push_back(32'hCAFE_0003);
    sb.push_back('{e: 1'b0, d: 32'hCAFE_0003});
    exp_rd = 32'hCAFE_0003;
    step();
    req = 1'b1; rw = READ; addr = 30'd3; wr_data = '0;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++; if (bus_as_ !== 1'b1 || bus_addr !== '0 || bus_req_ !== 1'b0) begin failures++; $display("FAIL gnt_wait_c%0d: as_=%b addr=%h req_=%b want 1 0 0", i, bus_as_, bus_addr, bus_req_); end
      if (i == 2) stray = 1'b1;
      if (i == 5) bus_grnt_ = 1'b0;
    end
    step();
    checks++; if (bus_as_ !== 1'b0 || bus_addr !== 30'd3) begin failures++; $display("FAIL gnt_as_after_grant: as_=%b addr=%h want 0 3", bus_as_, bus_addr); end
    bus_grnt_ = 1'b1;
    wait_done(20);
    checks++; if (!ok || cyc != 2) begin failures++; $display("FAIL gnt_done_latency: done=%b cycles=%0d want 1 2", ok, cyc); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL gnt_rd_data: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    req = 1'b0;
    bus_grnt_ = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    exp_t e;
    slave_lat = 0;
    sb.push_back('{e: 1'b1, d: '0});
    exp_rd = '0;
    step();
    req = 1'b1; rw = READ; addr = 30'd4; wr_data = '0;
    wait_done(30);
    checks++; if (!ok || cyc != 6) begin failures++; $display("FAIL to_latency: done=%b cycles=%0d want 1 6", ok, cyc); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL to_abort: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    req = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_pulse: got %b want 0", err); end
    // Ready arrives on the very edge the watchdog would expire.
    slave_lat = 3;
    slave_q.push_back(32'hA5A5_0004);
    sb.push_back('{e: 1'b0, d: 32'hA5A5_0004});
    exp_rd = 32'hA5A5_0004;
    step();
    req = 1'b1; rw = READ; addr = 30'd5;
    wait_done(30);
    checks++; if (!ok || cyc != 6) begin failures++; $display("FAIL to_edge_latency: done=%b cycles=%0d want 1 6", ok, cyc); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL to_edge_rdy_wins: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    slave_lat = 0;
    step();
    req = 1'b1; rw = READ; addr = 30'd6;
    step(); step();
    checks++; if (bus_as_ !== 1'b0) begin failures++; $display("FAIL rstmid_in_access: as_=%b want 0", bus_as_); end
    rst = 1'b0;
    #1;
    exp_rd = '0;
    checks++; if (bus_as_ !== 1'b1 || bus_req_ !== 1'b1) begin failures++; $display("FAIL rstmid_strobes: as_=%b req_=%b want 1 1", bus_as_, bus_req_); end
    checks++; if (rd_data !== exp_rd || bus_addr !== '0) begin failures++; $display("FAIL rstmid_regs: rd=%h addr=%h want 0 0", rd_data, bus_addr); end
    req = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    slave_lat = 1;
    slave_q.push_back(32'h7777_0007);
    sb.push_back('{e: 1'b0, d: 32'h7777_0007});
    exp_rd = 32'h7777_0007;
    step();
    req = 1'b1; rw = READ; addr = 30'd7;
    wait_done(20);
    checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL rstmid_after_latency: done=%b cycles=%0d want 1 4", ok, cyc); end
    e = sb.pop_front();
    checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL rstmid_after_data: got %h err=%b want %h err=%b", rd_data, err, e.d, e.e); end
    req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n0;
    int np;
    slave_lat = 1;
    for (int k = 1; k <= 3; k++) begin
      slave_q.push_back(DW'(k));
      sb.push_back('{e: 1'b0, d: DW'(k)});
    end
    n0 = as_cnt;
    step();
    req = 1'b1; rw = READ; addr = 30'd8;
    for (int k = 0; k < 3; k++) begin
      np = as_cnt;
      wait_done(20);
      checks++; if (!ok || cyc != ((k == 0) ? 4 : 5)) begin failures++; $display("FAIL b2b_latency_%0d: done=%b cycles=%0d want 1 %0d", k, ok, cyc, (k == 0) ? 4 : 5); end
      e = sb.pop_front();
      checks++; if (rd_data !== e.d || err !== e.e) begin failures++; $display("FAIL b2b_data_%0d: got %h err=%b want %h err=%b", k, rd_data, err, e.d, e.e); end
      checks++; if (as_cnt - np != 1 || as_addr !== 30'd8 + AW'(k)) begin failures++; $display("FAIL b2b_strobe_%0d: strobes=%0d addr=%h want 1 %h", k, as_cnt - np, as_addr, 30'd8 + AW'(k)); end
      addr = addr + 30'd1;
    end
    req = 1'b0;
    step();
    checks++; if (as_cnt - n0 != 3) begin failures++; $display("FAIL b2b_total_strobes: got %0d want 3", as_cnt - n0); end
  endtask

  initial begin
    test_reset();
    test_read_timer();
    test_write();
    test_grant_delay();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
